// File: rtl/mm2st_dma_reader.sv
// mm2st_dma_reader: Avalon-MM read master that fetches LENGTH 32-bit words
// starting at base_addr into a small FIFO and streams them out as one
// Avalon-ST packet of 16-bit samples (low half first, then high half).
// Reads are credit-limited so outstanding reads plus buffered words never
// exceed FIFO_DEPTH.
// Optional build macro: MM2ST_BYTESWAP_EN -- swaps the two bytes of every
// emitted sample; timing and handshake are unchanged.
module mm2st_dma_reader #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic [1:0]        avm_response,
  output logic [15:0]       aso_data,
  output logic              aso_valid,
  input  logic              aso_ready,
  output logic              aso_startofpacket,
  output logic              aso_endofpacket
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state;
  logic [31:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        fifo_cnt;
  logic [PW:0]        outstanding;
  logic [LEN_W-1:0]   cmd_left;
  logic [LEN_W:0]     samp_left;
  logic               upper;
  logic               first;

  logic               accept;
  logic               push;
  logic               pop;
  logic               hs;
  logic               last_hs;
  logic [PW:0]        out_nxt;
  logic [PW:0]        cnt_nxt;
  logic [PW+1:0]      credit;
  logic [LEN_W-1:0]   cmd_left_nxt;
  logic [15:0]        sample;

  function automatic logic [15:0] order_sample(input logic [15:0] d);
`ifdef MM2ST_BYTESWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  // Handshake decode and next-cycle occupancy used by the credit check.
  // Read data is only accepted while reads are outstanding, so beats left
  // over from an aborted transfer are dropped.
  always_comb begin
    accept       = avm_read & ~avm_waitrequest;
    push         = avm_readdatavalid & (outstanding != '0);
    hs           = aso_valid & aso_ready;
    pop          = hs & upper;
    last_hs      = hs & aso_endofpacket;
    out_nxt      = outstanding + (PW+1)'(accept) - (PW+1)'(push);
    cnt_nxt      = fifo_cnt + (PW+1)'(push) - (PW+1)'(pop);
    credit       = {1'b0, out_nxt} + {1'b0, cnt_nxt};
    cmd_left_nxt = cmd_left - LEN_W'(accept);
    sample       = upper ? mem[rd_ptr][31:16] : mem[rd_ptr][15:0];
  end

  assign avm_byteenable    = 4'b1111;
  assign aso_valid         = busy & (fifo_cnt != '0);
  assign aso_data          = aso_valid ? order_sample(sample) : 16'h0000;
  assign aso_startofpacket = aso_valid & first;
  assign aso_endofpacket   = aso_valid & (samp_left == (LEN_W+1)'(1));

  // Read-data storage; contents need no reset because fifo_cnt guards them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= avm_readdata;
  end

  // Transfer FSM, read issue with credit limit, FIFO pointers and stream counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      cmd_left    <= '0;
      samp_left   <= '0;
      upper       <= 1'b0;
      first       <= 1'b0;
    end else begin
      done        <= 1'b0;
      fifo_cnt    <= cnt_nxt;
      outstanding <= out_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && (avm_response != 2'b00)) err <= 1'b1;
      if (accept) avm_address <= avm_address + ADDR_W'(4);
      if (hs) begin
        samp_left <= samp_left - (LEN_W+1)'(1);
        upper     <= ~upper;
        first     <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              state       <= ISSUE;
              busy        <= 1'b1;
              avm_read    <= 1'b1;
              avm_address <= base_addr & ~ADDR_W'(3);
              cmd_left    <= length;
              samp_left   <= {length, 1'b0};
              upper       <= 1'b0;
              first       <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cmd_left <= cmd_left_nxt;
          // A stalled command is held untouched; otherwise decide afresh.
          if (!(avm_read && avm_waitrequest)) begin
            if (cmd_left_nxt == '0) begin
              avm_read <= 1'b0;
              state    <= DRAIN;
            end else begin
              avm_read <= (credit < (PW+2)'(FIFO_DEPTH));
            end
          end
        end
        DRAIN: begin
          if (last_hs) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm2st_dma_reader.sv
// Bench for mm2st_dma_reader: a randomised Avalon-MM slave / Avalon-ST sink
// model runs on the falling edge; scenario tasks launch transfers and compare
// the logged traffic with expectations built from the memory image.
`timescale 1ns/1ps
module tb_mm2st_dma_reader;
  localparam int ADDR_W = 32, FIFO_DEPTH = 16, LEN_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy, done, err;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [1:0]        avm_response;
  logic [15:0]       aso_data;
  logic              aso_valid, aso_ready, aso_startofpacket, aso_endofpacket;

  always #5 clk = ~clk;

  mm2st_dma_reader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_response(avm_response),
    .aso_data(aso_data), .aso_valid(aso_valid), .aso_ready(aso_ready),
    .aso_startofpacket(aso_startofpacket), .aso_endofpacket(aso_endofpacket));

  int n_cmp = 0, n_fail = 0;
  logic [31:0] mem_words [1024];

  // Model knobs.
  int wait_pct = 0, ready_pct = 100, rd_lat = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  // Logged traffic and monitor statistics.
  logic [31:0] log_addr[$];
  logic [15:0] log_data[$];
  logic        log_sop[$];
  logic        log_eop[$];
  int done_cnt, stall_viol, hold_viol, max_infl, read_cycles, valid_cycles;
  int first_rv, first_vl, cyc = 0;
  int accepted = 0, popped = 0, hs_cnt = 0;

  typedef struct {int due; logic [31:0] data; logic [1:0] resp;} beat_t;
  beat_t pend[$];

  // Slave + sink model; all DUT inputs of the bus side are driven here.
  initial begin : bfm
    logic p_rd, p_wr, p_vl, p_rdy, p_sop, p_eop, wr, rdy;
    logic [31:0] p_addr;
    logic [15:0] p_data;
    beat_t b;
    p_rd = 0; p_wr = 0; p_vl = 0; p_rdy = 0; p_sop = 0; p_eop = 0; p_addr = 0; p_data = 0;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0; avm_response = 0; aso_ready = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        accepted = 0; popped = 0; hs_cnt = 0;
        avm_waitrequest = 0; avm_readdatavalid = 0; avm_response = 0; aso_ready = 0;
        p_rd = 0; p_vl = 0;
      end else begin
        if (accepted - popped > max_infl) max_infl = accepted - popped;
        if (p_rd && p_wr && (avm_read !== 1'b1 || avm_address !== p_addr)) stall_viol++;
        if (avm_read && avm_byteenable !== 4'hF) stall_viol++;
        if (p_vl && !p_rdy && (aso_valid !== 1'b1 || aso_data !== p_data ||
            aso_startofpacket !== p_sop || aso_endofpacket !== p_eop)) hold_viol++;
        if (done) done_cnt++;
        if (avm_read) read_cycles++;
        if (aso_valid) begin
          valid_cycles++;
          if (first_vl < 0) first_vl = cyc;
        end
        avm_readdatavalid = 0;
        avm_response = 0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          b = pend.pop_front();
          avm_readdatavalid = 1; avm_readdata = b.data; avm_response = b.resp;
          if (first_rv < 0) first_rv = cyc;
        end
        wr = ($urandom_range(99) < wait_pct);
        avm_waitrequest = wr;
        if (avm_read && !wr) begin
          log_addr.push_back(avm_address);
          b.due = cyc + rd_lat;
          b.data = mem_words[avm_address[11:2]];
          b.resp = (avm_address == err_addr) ? 2'b10 : 2'b00;
          pend.push_back(b);
          accepted++;
        end
        rdy = ($urandom_range(99) < ready_pct);
        aso_ready = rdy;
        if (aso_valid && rdy) begin
          log_data.push_back(aso_data);
          log_sop.push_back(aso_startofpacket);
          log_eop.push_back(aso_endofpacket);
          hs_cnt++;
          if (hs_cnt % 2 == 0) popped++;
        end
        p_rd = avm_read; p_wr = wr; p_addr = avm_address;
        p_vl = aso_valid; p_rdy = rdy; p_data = aso_data;
        p_sop = aso_startofpacket; p_eop = aso_endofpacket;
      end
    end
  end

  // Reference: k-th sample of a transfer starting at word-aligned address b.
  function automatic logic [15:0] exp_sample(input logic [31:0] b, input int k);
    int idx;
    logic [31:0] w;
    logic [15:0] h;
    idx = (int'(b[11:2]) + k / 2) % 1024;
    w = mem_words[idx];
    h = (k % 2 == 1) ? w[31:16] : w[15:0];
`ifdef MM2ST_BYTESWAP_EN
    h = {h[7:0], h[15:8]};
`endif
    return h;
  endfunction

  task automatic clear_logs();
    log_addr.delete(); log_data.delete(); log_sop.delete(); log_eop.delete();
    done_cnt = 0; stall_viol = 0; hold_viol = 0; max_infl = 0;
    read_cycles = 0; valid_cycles = 0; first_rv = -1; first_vl = -1;
  endtask

  task automatic launch(input logic [31:0] b, input int len);
    @(posedge clk); #2;
    clear_logs();
    base_addr = b; length = len[LEN_W-1:0]; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #2;
      if (done_cnt > 0) begin timed_out = 0; break; end
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, avm_read, aso_valid, aso_startofpacket, aso_endofpacket} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000000",
        {busy, done, err, avm_read, aso_valid, aso_startofpacket, aso_endofpacket});
    end
    n_cmp++;
    if (avm_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", avm_address); end
    n_cmp++;
    if (aso_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", aso_data); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if ({busy, avm_read} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset: got %b want 00", {busy, avm_read}); end
  endtask

  task automatic test_basic();
    logic [15:0] exp [6];
    logic [15:0] e;
    bit to;
    mem_words[0] = 32'hBBBBAAAA; mem_words[1] = 32'hDDDDCCCC; mem_words[2] = 32'hFFFFEEEE;
    exp = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
    wait_pct = 0; ready_pct = 100; rd_lat = 1; err_addr = 32'hFFFF_FFFF;
    launch(32'h1000, 3);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(200, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: no done within 200 cycles"); end
    n_cmp++;
    if (log_addr.size() !== 3) begin n_fail++; $display("FAIL basic_ncmd: got %0d want 3", log_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= log_addr.size() || log_addr[i] !== 32'h1000 + 32'(4 * i)) begin
        n_fail++; $display("FAIL basic_addr[%0d]: got %h want %h", i,
          (i < log_addr.size()) ? log_addr[i] : 32'hx, 32'h1000 + 32'(4 * i));
      end
    end
    n_cmp++;
    if (log_data.size() !== 6) begin n_fail++; $display("FAIL basic_nsamp: got %0d want 6", log_data.size()); end
    for (int i = 0; i < 6 && i < log_data.size(); i++) begin
      e = exp[i];
`ifdef MM2ST_BYTESWAP_EN
      e = {e[7:0], e[15:8]};
`endif
      n_cmp++;
      if ({log_data[i], log_sop[i], log_eop[i]} !== {e, i == 0, i == 5}) begin
        n_fail++; $display("FAIL basic_sample[%0d]: got %h sop%b eop%b want %h sop%b eop%b", i,
          log_data[i], log_sop[i], log_eop[i], e, i == 0, i == 5);
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
    n_cmp++;
    if ({err, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_err_busy: got %b want 00", {err, busy}); end
    n_cmp++;
    if (first_vl - first_rv !== 1) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles want 1", first_vl - first_rv);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] b;
    int bad;
    bit to;
    b = $urandom & 32'hFFFF_FFFC;
    wait_pct = 0; ready_pct = 0; rd_lat = 3;
    launch(b, 64);
    repeat (40) @(posedge clk);
    #2;
    ready_pct = 100;
    wait_done(3000, to);
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL bp_timeout: no done within 3000 cycles"); end
    n_cmp++;
    if (max_infl > FIFO_DEPTH) begin n_fail++; $display("FAIL bp_credit: got %0d in flight want <= %0d", max_infl, FIFO_DEPTH); end
    n_cmp++;
    if (log_addr.size() !== 64) begin n_fail++; $display("FAIL bp_ncmd: got %0d want 64", log_addr.size()); end
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (i >= log_data.size() || log_data[i] !== exp_sample(b, i)) bad++;
    n_cmp++;
    if (bad !== 0 || log_data.size() !== 128) begin
      n_fail++; $display("FAIL bp_samples: got %0d samples with %0d wrong want 128 with 0 wrong", log_data.size(), bad);
    end
    n_cmp++;
    if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_viol); end
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_waitrequest();
    logic [31:0] b;
    int len, bad;
    bit to;
    b = $urandom & 32'hFFFF_FFFC;
    len = $urandom_range(40, 20);
    wait_pct = 50; ready_pct = 70; rd_lat = 2;
    launch(b, len);
    wait_done(3000, to);
    wait_pct = 0; ready_pct = 100;
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL wr_timeout: no done within 3000 cycles"); end
    n_cmp++;
    if (stall_viol !== 0) begin n_fail++; $display("FAIL wr_stall_stable: got %0d violations want 0", stall_viol); end
    n_cmp++;
    if (log_addr.size() !== len) begin n_fail++; $display("FAIL wr_ncmd: got %0d want %0d", log_addr.size(), len); end
    bad = 0;
    for (int i = 0; i < len && i < log_addr.size(); i++)
      if (log_addr[i] !== b + 32'(4 * i)) bad++;
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL wr_addr: got %0d wrong addresses want 0", bad); end
    bad = 0;
    for (int i = 0; i < 2 * len; i++)
      if (i >= log_data.size() || log_data[i] !== exp_sample(b, i)) bad++;
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL wr_samples: got %0d wrong samples want 0", bad); end
    n_cmp++;
    if (hold_viol !== 0) begin n_fail++; $display("FAIL wr_hold: got %0d unstable stalls want 0", hold_viol); end
  endtask

  task automatic test_error();
    logic [31:0] b, b2;
    int bad;
    bit to;
    b = $urandom & 32'hFFFF_FFFC;
    b2 = $urandom & 32'hFFFF_FFFC;
    wait_pct = 0; ready_pct = 100; rd_lat = 1;
    err_addr = b + 32'h4;
    launch(b, 4);
    wait_done(300, to);
    err_addr = 32'hFFFF_FFFF;
    n_cmp++;
    if (to || done_cnt !== 1) begin n_fail++; $display("FAIL err_done: got %0d pulses want 1", done_cnt); end
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (i >= log_data.size() || log_data[i] !== exp_sample(b, i)) bad++;
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL err_samples: got %0d wrong samples want 0", bad); end
    launch(b2, 2);
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
    wait_done(300, to);
    n_cmp++;
    if (to || err !== 1'b0) begin n_fail++; $display("FAIL err_clean_xfer: got err=%b timeout=%0d want 0/0", err, to); end
  endtask

  task automatic test_zero_len_and_busy();
    logic [31:0] b;
    int bad;
    bit to;
    wait_pct = 0; ready_pct = 100; rd_lat = 1;
    launch($urandom & 32'hFFFF_FFFC, 0);
    n_cmp++;
    if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL zero_done: got done/busy %b want 10", {done, busy}); end
    @(posedge clk); #2;
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: got %b want 0", done); end
    repeat (5) @(posedge clk);
    #2;
    n_cmp++;
    if (read_cycles !== 0 || valid_cycles !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_quiet: got reads %0d valids %0d dones %0d want 0 0 1", read_cycles, valid_cycles, done_cnt);
    end
    b = $urandom & 32'hFFFF_FFFC;
    launch(b, 8);
    repeat (4) @(posedge clk);
    #2;
    base_addr = b + 32'h100; length = 3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(300, to);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (i >= log_addr.size() || log_addr[i] !== b + 32'(4 * i)) bad++;
    n_cmp++;
    if (bad !== 0 || log_addr.size() !== 8) begin
      n_fail++; $display("FAIL busy_start_addr: got %0d cmds %0d wrong want 8 0", log_addr.size(), bad);
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (i >= log_data.size() || log_data[i] !== exp_sample(b, i)) bad++;
    n_cmp++;
    if (bad !== 0 || log_data.size() !== 16 || done_cnt !== 1) begin
      n_fail++; $display("FAIL busy_start_stream: got %0d samples %0d wrong %0d dones want 16 0 1", log_data.size(), bad, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] b;
    int bad;
    bit to;
    wait_pct = 0; ready_pct = 100; rd_lat = 1;
    launch($urandom & 32'hFFFF_FFFC, 10);
    to = 1;
    for (int i = 0; i < 200; i++) begin
      if (log_addr.size() >= 5) begin to = 0; break; end
      @(posedge clk); #2;
    end
    n_cmp++;
    if (to) begin n_fail++; $display("FAIL rst_mid_progress: got %0d cmds want >= 5", log_addr.size()); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, err, avm_read, aso_valid, aso_startofpacket, aso_endofpacket} !== 7'b0 ||
        avm_address !== 32'h0 || aso_data !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got ctrl %b addr %h data %h want all 0",
        {busy, done, err, avm_read, aso_valid, aso_startofpacket, aso_endofpacket}, avm_address, aso_data);
    end
    repeat (2) @(posedge clk);
    #2;
    done_cnt = 0;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    n_cmp++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_nodone: got %0d dones busy %b want 0 0", done_cnt, busy);
    end
    b = $urandom & 32'hFFFF_FFFC;
    launch(b, 2);
    wait_done(300, to);
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= log_data.size() || log_data[i] !== exp_sample(b, i)) bad++;
    n_cmp++;
    if (to || bad !== 0 || log_data.size() !== 4 || done_cnt !== 1) begin
      n_fail++; $display("FAIL rst_mid_after: got %0d samples %0d wrong %0d dones want 4 0 1", log_data.size(), bad, done_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    for (int i = 0; i < 1024; i++) mem_words[i] = $urandom;
    test_reset();
    test_basic();
    test_backpressure();
    test_waitrequest();
    test_error();
    test_zero_len_and_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
